// File: rtl/led_key_if.sv
// Key-event inputs and LED pin bundle for the front-panel LED driver.
// Carries the brightness input only when LED_PWM_EN is defined.
interface led_key_if #(
    parameter int CODE_W = 4,
    parameter int PWM_W  = 4
);
    logic              is_pressed;
    logic [CODE_W-1:0] keyboard_data;
`ifdef LED_PWM_EN
    logic [PWM_W-1:0]  brightness;
`endif
    logic [CODE_W:0]   led;

    modport master (
        output is_pressed,
        output keyboard_data,
`ifdef LED_PWM_EN
        output brightness,
`endif
        input  led
    );

    modport slave (
        input  is_pressed,
        input  keyboard_data,
`ifdef LED_PWM_EN
        input  brightness,
`endif
        output led
    );
endinterface

// File: rtl/led_key_indicator.sv
// Active-low LED driver: shows the held key code, then holds it with a blinking indicator.
// Optional LED_PWM_EN adds a brightness input that duty-cycles every lit LED.
module led_key_indicator #(
    parameter int CODE_W    = 4,
    parameter int HOLD_CYC  = 25_000_000,
    parameter int BLINK_CYC = 5_000_000,
    parameter int PWM_W     = 4
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    led_key_if.slave kif
);
    localparam int LW = CODE_W + 1;
    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam logic [HW-1:0] HOLD_INIT = (HOLD_CYC > 0) ? HW'(HOLD_CYC - 1) : '0;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_e;

    state_e            state_q, state_d;
    logic              press_q, press_d;
    logic              press_qq_q, press_qq_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] lat_q, lat_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [LW-1:0]     led_q, led_d;
    logic              rise, fall;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            press_q    <= 1'b0;
            press_qq_q <= 1'b0;
            code_q     <= '0;
            lat_q      <= '0;
            hold_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            led_q      <= '1;
        end else begin
            state_q    <= state_d;
            press_q    <= press_d;
            press_qq_q <= press_qq_d;
            code_q     <= code_d;
            lat_q      <= lat_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        press_d    = kif.is_pressed;
        code_d     = kif.keyboard_data;
        press_qq_d = press_q;
        rise       = press_q & ~press_qq_q;
        fall       = ~press_q & press_qq_q;
        state_d    = state_q;
        lat_d      = lat_q;
        hold_d     = hold_q;
        blink_d    = blink_q;
        phase_d    = phase_q;
        led_d      = '1;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                    lat_d   = code_q;
                end
            end
            PRESS: begin
                // Code on the release cycle is not trusted; keep the last one.
                if (fall) begin
                    if (HOLD_CYC > 0) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                        blink_d = '0;
                        phase_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_d = code_q;
                end
            end
            HOLD: begin
                if (rise) begin
                    state_d = PRESS;
                    lat_d   = code_q;
                end else if (hold_q == '0) begin
                    state_d = IDLE;
                    blink_d = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                    if (blink_q == BLINK_LAST) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            PRESS:   led_d = {1'b0, ~lat_d};
            HOLD:    led_d = {~phase_d, ~lat_d};
            default: led_d = '1;
        endcase
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_on;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pwm_cnt_q <= '0;
        else            pwm_cnt_q <= pwm_cnt_d;
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_on    = pwm_cnt_q < kif.brightness;
    end

    assign kif.led = led_q | {LW{~pwm_on}};
`else
    assign kif.led = led_q;
`endif
endmodule

// File: tb/tb_led_key_indicator.sv
// Scoreboard bench for led_key_indicator with CODE_W=4, HOLD_CYC=20, BLINK_CYC=4.
// Stimulus queues the LED value expected two edges later; a monitor pops and compares.
module tb_led_key_indicator;
    localparam int CW = 4;
    localparam int HC = 20;
    localparam int BC = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    led_key_if #(.CODE_W(CW), .PWM_W(4)) kif ();

    led_key_indicator #(
        .CODE_W(CW), .HOLD_CYC(HC), .BLINK_CYC(BC), .PWM_W(4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .kif      (kif.slave)
    );

    typedef struct {
        int         due;
        logic [4:0] exp;
        logic [4:0] mask;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

`ifdef LED_PWM_EN
    logic [3:0] tb_pwm;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tb_pwm <= '0;
        else            tb_pwm <= tb_pwm + 4'd1;
    end
`endif

    function automatic logic [4:0] shown(input logic [4:0] e);
`ifdef LED_PWM_EN
        return e | {5{~(tb_pwm < 4'd8)}};
`else
        return e;
`endif
    endfunction

    always @(negedge sys_clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            cur = q.pop_front();
            total++;
            if (cur.due != cyc) begin
                bad++;
                $display("FAIL %s stale: due=%0d now=%0d", cur.tag, cur.due, cyc);
            end else if (((kif.led ^ shown(cur.exp)) & cur.mask) != 5'd0) begin
                bad++;
                $display("FAIL %s cyc=%0d led=%b want=%b", cur.tag, cyc,
                         kif.led, shown(cur.exp));
            end
        end
    end

    function automatic logic [4:0] hp(input int n, input logic [3:0] code);
        logic ind;
        ind = ((n / BC) % 2) != 0;
        return {ind, ~code};
    endfunction

    task automatic tick(input logic p, input logic [3:0] c,
                        input logic [4:0] e, input string tag);
        @(posedge sys_clk);
        #1;
        kif.is_pressed    = p;
        kif.keyboard_data = c;
        q.push_back('{cyc + 2, e, 5'h1f, tag});
    endtask

    task automatic chk(input string tag, input logic [4:0] got,
                       input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s led=%b want=%b", tag, got, want);
        end
    endtask

    initial begin
        int lit;
        kif.is_pressed    = 1'b0;
        kif.keyboard_data = 4'h0;
`ifdef LED_PWM_EN
        kif.brightness    = 4'h8;
`endif
        repeat (2) @(posedge sys_clk);
        #1 chk("reset_led", kif.led, 5'h1f);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        repeat (6) tick(1'b0, 4'h0, 5'h1f, "idle");
        repeat (6) tick(1'b1, 4'h3, 5'h0c, "press3");

        repeat (4) tick(1'b1, 4'ha, 5'h05, "pressA");
        for (int n = 0; n < HC; n++) tick(1'b0, 4'h0, hp(n, 4'ha), "holdA");
        repeat (4) tick(1'b0, 4'h0, 5'h1f, "holdA_end");

        repeat (3) tick(1'b1, 4'h5, 5'h0a, "press5");
        for (int n = 0; n < 10; n++) tick(1'b0, 4'h0, hp(n, 4'h5), "hold5");
        repeat (3) tick(1'b1, 4'hc, 5'h03, "repressC");
        for (int n = 0; n < HC; n++) tick(1'b0, 4'h0, hp(n, 4'hc), "holdC_full");
        repeat (2) tick(1'b0, 4'h0, 5'h1f, "holdC_end");

        repeat (2) tick(1'b1, 4'hd, 5'h02, "pressD");
        for (int n = 0; n < HC; n++) tick(1'b0, 4'h0, hp(n, 4'hd), "holdD");
        repeat (3) tick(1'b1, 4'h6, 5'h09, "rise_at_expiry");

        for (int n = 0; n < 6; n++) tick(1'b0, 4'h0, hp(n, 4'h6), "hold6");
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        q.delete();
        #1 chk("async_reset", kif.led, 5'h1f);
        repeat (2) @(posedge sys_clk);
        #1 chk("reset_held", kif.led, 5'h1f);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        repeat (3) tick(1'b0, 4'h0, 5'h1f, "idle_after_rst");
        repeat (4) tick(1'b1, 4'h3, 5'h0c, "press_after_rst");
        repeat (3) @(posedge sys_clk);

`ifdef LED_PWM_EN
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if (kif.led[4] == 1'b0) lit++;
        end
        chk("pwm_duty", 5'(lit), 5'd8);
`else
        lit = 0;
`endif

        repeat (2) @(posedge sys_clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
